// File: rtl/ex_mem_latch_if.sv
// ex_mem_latch_if: shared types plus the EX/MEM stage bus (upstream drives inputs, latch drives out_*/trap signals)
package ex_mem_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

interface ex_mem_latch_if #(parameter int RD_W = 5);
  import ex_mem_pkg::*;
  logic en, flush, exc_ack, in_valid;
  aluop_t aluop;
  word_t outport, storedata, pc;
  logic negative, zero, overflow;
  logic [RD_W-1:0] rd, out_rd;
  logic regwrite, memread, memwrite;
  logic out_valid, out_zero, out_negative, out_regwrite, out_memread, out_memwrite;
  word_t out_result, out_storedata, out_pc, epc;
  logic exc_ovf, stall_req;
  modport master (
    output en, flush, exc_ack, in_valid, aluop, outport, negative, zero, overflow,
           rd, regwrite, memread, memwrite, storedata, pc,
    input  out_valid, out_result, out_zero, out_negative, out_rd, out_regwrite,
           out_memread, out_memwrite, out_storedata, out_pc, exc_ovf, epc, stall_req
  );
  modport slave (
    input  en, flush, exc_ack, in_valid, aluop, outport, negative, zero, overflow,
           rd, regwrite, memread, memwrite, storedata, pc,
    output out_valid, out_result, out_zero, out_negative, out_rd, out_regwrite,
           out_memread, out_memwrite, out_storedata, out_pc, exc_ovf, epc, stall_req
  );
endinterface

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register with flush, validity gating and optional overflow trap (OVERFLOW_TRAP_EN).
module ex_mem_latch
  import ex_mem_pkg::*;
#(
  parameter int RD_W = 5
) (
  input logic          CLK,
  input logic          nRST,
  ex_mem_latch_if.slave bus
);
  logic            trap_ev, hold, capture, ctl_ok;
  logic            valid_q, zero_q, neg_q, rw_q, mr_q, mw_q;
  word_t           result_q, sd_q, pc_q;
  logic [RD_W-1:0] rd_q;
`ifdef OVERFLOW_TRAP_EN
  typedef enum logic {NORMAL, TRAP} state_t;
  state_t state_q, state_d;
  logic   exc_q;
  word_t  epc_q;
  always_comb begin
    trap_ev = state_q == NORMAL && bus.in_valid && bus.en && !bus.flush && bus.overflow &&
              (bus.aluop == ALU_ADD || bus.aluop == ALU_SUB);
    state_d = state_q == TRAP ? (bus.exc_ack ? NORMAL : TRAP) : (trap_ev ? TRAP : NORMAL);
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= NORMAL;
      exc_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= trap_ev;
      epc_q   <= trap_ev ? bus.pc : epc_q;
    end
  assign hold          = state_q == TRAP;
  assign bus.exc_ovf   = exc_q;
  assign bus.epc       = epc_q;
  assign bus.stall_req = hold;
`else
  logic unused_trap;
  assign trap_ev       = 1'b0;
  assign hold          = 1'b0;
  assign bus.exc_ovf   = 1'b0;
  assign bus.epc       = '0;
  assign bus.stall_req = 1'b0;
  assign unused_trap   = ^{bus.aluop, bus.overflow, bus.exc_ack};
`endif
  // A trapping instruction stays visible (valid) but must not commit any side effect.
  assign capture = bus.en && !hold;
  assign ctl_ok  = bus.in_valid && !trap_ev;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      result_q <= '0;
      sd_q     <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (capture) begin
      valid_q  <= bus.in_valid;
      zero_q   <= bus.zero;
      neg_q    <= bus.negative;
      rw_q     <= ctl_ok && bus.regwrite;
      mr_q     <= ctl_ok && bus.memread;
      mw_q     <= ctl_ok && bus.memwrite;
      result_q <= bus.outport;
      sd_q     <= bus.storedata;
      pc_q     <= bus.pc;
      rd_q     <= bus.rd;
    end
  assign bus.out_valid     = valid_q;
  assign bus.out_zero      = zero_q;
  assign bus.out_negative  = neg_q;
  assign bus.out_regwrite  = rw_q;
  assign bus.out_memread   = mr_q;
  assign bus.out_memwrite  = mw_q;
  assign bus.out_result    = result_q;
  assign bus.out_storedata = sd_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_rd        = rd_q;
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: directed steps with a queue of expected stage outputs, checked #1 after each clock edge.
module tb_ex_mem_latch;
  import ex_mem_pkg::*;
  typedef struct {
    logic v, z, n, rw, mr, mw, ovf, st, dc;
    word_t res, sd, pc, epc;
    logic [4:0] rd;
  } exp_t;
  logic CLK = 1'b0;
  logic nRST;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  ex_mem_latch_if #(.RD_W(5)) b();
  ex_mem_latch #(.RD_W(5)) dut (.CLK(CLK), .nRST(nRST), .bus(b));
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic en, fl, ack, iv, input aluop_t op, input word_t o,
                     input logic n, z, ov, input logic [4:0] rd, input logic rw, mr, mw,
                     input word_t sd, pc);
    b.en = en; b.flush = fl; b.exc_ack = ack; b.in_valid = iv; b.aluop = op;
    b.outport = o; b.negative = n; b.zero = z; b.overflow = ov; b.rd = rd;
    b.regwrite = rw; b.memread = mr; b.memwrite = mw; b.storedata = sd; b.pc = pc;
  endtask

  task automatic ex(input logic v, input word_t res, input logic z, n, input logic [4:0] rd,
                    input logic rw, mr, mw, input word_t sd, pc, input logic ovf,
                    input word_t epc, input logic st, input logic dc = 1'b0);
    exp_t e;
    e.v = v; e.res = res; e.z = z; e.n = n; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    e.sd = sd; e.pc = pc; e.ovf = ovf; e.epc = epc; e.st = st; e.dc = dc;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk("out_valid", 32'(b.out_valid), 32'(e.v));
    chk("out_regwrite", 32'(b.out_regwrite), 32'(e.rw));
    chk("out_memread", 32'(b.out_memread), 32'(e.mr));
    chk("out_memwrite", 32'(b.out_memwrite), 32'(e.mw));
    chk("exc_ovf", 32'(b.exc_ovf), 32'(e.ovf));
    chk("epc", b.epc, e.epc);
    chk("stall_req", 32'(b.stall_req), 32'(e.st));
    if (!e.dc) begin
      chk("out_result", b.out_result, e.res);
      chk("out_zero", 32'(b.out_zero), 32'(e.z));
      chk("out_negative", 32'(b.out_negative), 32'(e.n));
      chk("out_rd", 32'(b.out_rd), 32'(e.rd));
      chk("out_storedata", b.out_storedata, e.sd);
      chk("out_pc", b.out_pc, e.pc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check_now();
  endtask

  initial begin
    nRST = 1'b1;
    drv(0,0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0,0);
    #1 nRST = 1'b0;
    #1;
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0); check_now();
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0); tick();
    nRST = 1'b1;
    // basic capture, flags, validity gating, store
    drv(1,0,0,1,ALU_ADD,32'h10,0,0,0,5,1,0,0,32'hAA,32'h100);
    ex(1,32'h10,0,0,5,1,0,0,32'hAA,32'h100,0,0,0); tick();
    drv(1,0,0,1,ALU_SUB,0,0,1,0,3,1,1,0,0,32'h104);
    ex(1,0,1,0,3,1,1,0,0,32'h104,0,0,0); tick();
    drv(1,0,0,0,ALU_AND,32'h55,1,0,0,7,1,1,1,32'h33,32'h108);
    ex(0,32'h55,0,1,7,0,0,0,32'h33,32'h108,0,0,0); tick();
    drv(1,0,0,1,ALU_ADD,32'h200,0,0,0,0,0,0,1,32'hDEADBEEF,32'h10C);
    ex(1,32'h200,0,0,0,0,0,1,32'hDEADBEEF,32'h10C,0,0,0); tick();
    // hold with en=0 while inputs (including an overflowing ADD) change
    for (int i = 0; i < 3; i++) begin
      drv(0,0,0,1,ALU_ADD,32'h1000 + 32'(i),i[0],1,1,5'(i + 1),1,1,0,32'(i),32'h200 + 32'(i));
      ex(1,32'h200,0,0,0,0,0,1,32'hDEADBEEF,32'h10C,0,0,0); tick();
    end
    // flush with en=1 and en=0
    drv(1,1,0,1,ALU_ADD,32'h300,0,0,0,2,1,1,1,32'h1,32'h110);
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0,1); tick();
    drv(0,1,0,1,ALU_ADD,32'h300,0,0,0,2,1,1,1,32'h1,32'h110);
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0,1); tick();
    // overflow on SLT never traps
    drv(1,0,0,1,ALU_SLT,32'h1,0,0,1,9,1,0,0,0,32'h114);
    ex(1,32'h1,0,0,9,1,0,0,0,32'h114,0,0,0); tick();
    // 0x7FFF_FFFF + 1 overflowing ADD
    drv(1,0,0,1,ALU_ADD,32'h80000000,1,0,1,4,1,0,0,32'h5,32'h40);
`ifdef OVERFLOW_TRAP_EN
    ex(1,32'h80000000,0,1,4,0,0,0,32'h5,32'h40,1,32'h40,1); tick();
    drv(1,0,0,1,ALU_ADD,32'h123,0,0,0,6,1,1,0,32'h9,32'h44);
    ex(1,32'h80000000,0,1,4,0,0,0,32'h5,32'h40,0,32'h40,1); tick();
    drv(0,1,0,1,ALU_ADD,32'h124,0,0,0,6,1,1,1,32'h9,32'h48);
    ex(0,0,0,0,0,0,0,0,0,0,0,32'h40,1,1); tick();
    drv(1,0,1,1,ALU_ADD,32'h125,0,0,0,6,1,1,1,32'h9,32'h4C);
    ex(0,0,0,0,0,0,0,0,0,0,0,32'h40,0,1); tick();
    drv(1,0,1,1,ALU_SUB,32'h77,0,0,0,2,1,0,0,0,32'h48);
    ex(1,32'h77,0,0,2,1,0,0,0,32'h48,0,32'h40,0); tick();
    drv(1,1,0,1,ALU_ADD,32'h80000000,1,0,1,4,1,0,0,0,32'h50);
    ex(0,0,0,0,0,0,0,0,0,0,0,32'h40,0,1); tick();
    drv(1,0,0,1,ALU_ADD,32'h99,0,0,0,1,1,0,0,0,32'h54);
    ex(1,32'h99,0,0,1,1,0,0,0,32'h54,0,32'h40,0); tick();
    drv(1,0,0,1,ALU_SUB,32'h7,0,0,1,8,0,1,1,32'hC,32'h60);
    ex(1,32'h7,0,0,8,0,0,0,32'hC,32'h60,1,32'h60,1); tick();
    drv(0,0,0,0,ALU_ADD,0,0,0,0,0,0,0,0,0,0);
    ex(1,32'h7,0,0,8,0,0,0,32'hC,32'h60,0,32'h60,1); tick();
`else
    ex(1,32'h80000000,0,1,4,1,0,0,32'h5,32'h40,0,0,0); tick();
    drv(0,0,1,0,ALU_ADD,0,0,0,0,0,0,0,0,0,0);
    ex(1,32'h80000000,0,1,4,1,0,0,32'h5,32'h40,0,0,0); tick();
`endif
    // asynchronous reset between edges, held across an edge, then released
    nRST = 1'b0;
    #1;
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0); check_now();
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0); tick();
    nRST = 1'b1;
    ex(0,0,0,0,0,0,0,0,0,0,0,0,0); tick();
    drv(1,0,0,1,ALU_XOR,32'h5,0,0,0,5,1,0,0,0,32'h70);
    ex(1,32'h5,0,0,5,1,0,0,0,32'h70,0,0,0); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
